// File: rtl/mux_scan_pkg.sv
// Shared mode encodings and FSM state type for the scanning multiplexer.
package mux_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_e;

endpackage

// File: rtl/mux_next_ch.sv
// Rotate-priority finder: first enabled channel strictly above i_ptr, wrapping modulo N.
module mux_next_ch #(
    parameter  int unsigned N     = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     i_en_mask,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_next,
    output logic             o_found,
    output logic             o_wrapped
);

    int               w_sum;
    logic [SEL_W-1:0] w_idx;

    // Walk from the farthest candidate (i_ptr itself) to the nearest so the nearest wins.
    always_comb begin
        o_next    = i_ptr;
        o_found   = 1'b0;
        o_wrapped = 1'b0;
        w_sum     = 0;
        w_idx     = '0;
        for (int k = int'(N); k >= 1; k--) begin
            w_sum = int'(i_ptr) + k;
            if (w_sum >= int'(N)) begin
                w_sum = w_sum - int'(N);
            end
            w_idx = SEL_W'(w_sum);
            if (i_en_mask[w_idx]) begin
                o_next    = w_idx;
                o_found   = 1'b1;
                o_wrapped = (w_idx <= i_ptr);
            end
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered multiplexer with manual select and autonomous dwell-based scanning.
module mux_scan_n
    import mux_scan_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned N     = 4,
    parameter  int unsigned DWELL = 4,
    localparam int unsigned SEL_W = $clog2(N)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N*WIDTH-1:0] i_in,
    input  logic [SEL_W-1:0]   i_sel,
    input  logic               i_mode,
    input  logic [N-1:0]       i_en_mask,
    output logic [WIDTH-1:0]   o_out,
    output logic [SEL_W-1:0]   o_out_ch,
    output logic               o_out_valid,
    output logic               o_wrap
);

    localparam int unsigned      DCW        = $clog2(DWELL + 1);
    localparam logic [DCW-1:0]   DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [SEL_W:0]   N_EXT      = (SEL_W + 1)'(N);

    state_e           r_state, w_state_d;
    logic [SEL_W-1:0] r_ptr, w_ptr_d;
    logic [DCW-1:0]   r_dwell, w_dwell_d, w_dwell_eff;
    logic [WIDTH-1:0] r_out, w_out_d;
    logic [SEL_W-1:0] r_out_ch, w_out_ch_d;
    logic             r_out_valid, w_out_valid_d;
    logic             r_wrap, w_wrap_d;
    // Set on a wrapping advance; surfaces as o_wrap alongside the first output of the new ptr.
    logic             r_wrap_pend, w_wrap_pend_d;

    logic             w_sel_ok;
    logic [SEL_W-1:0] w_sel_idx;
    logic [WIDTH-1:0] w_sel_data, w_ptr_data;
    logic [SEL_W-1:0] w_next;
    logic             w_found, w_wrapped;

    assign w_sel_ok   = ({1'b0, i_sel} < N_EXT);
    assign w_sel_idx  = w_sel_ok ? i_sel : '0;
    assign w_sel_data = i_in[w_sel_idx*WIDTH +: WIDTH];
    assign w_ptr_data = i_in[r_ptr*WIDTH +: WIDTH];

    mux_next_ch #(
        .N (N)
    ) u_next_ch (
        .i_en_mask (i_en_mask),
        .i_ptr     (r_ptr),
        .o_next    (w_next),
        .o_found   (w_found),
        .o_wrapped (w_wrapped)
    );

    always_comb begin
        w_state_d     = (i_mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        w_ptr_d       = r_ptr;
        w_dwell_d     = r_dwell;
        w_out_d       = r_out;
        w_out_ch_d    = r_out_ch;
        w_out_valid_d = r_out_valid;
        w_wrap_d      = 1'b0;
        w_wrap_pend_d = 1'b0;
        w_dwell_eff   = (r_state == ST_SCAN) ? r_dwell : '0;

        unique case (w_state_d)
            ST_MANUAL: begin
                w_out_d       = w_sel_ok ? w_sel_data : '0;
                w_out_ch_d    = i_sel;
                w_out_valid_d = w_sel_ok && i_en_mask[w_sel_idx];
                w_ptr_d       = w_sel_idx;
                w_dwell_d     = '0;
            end
            ST_SCAN: begin
                w_out_ch_d = r_ptr;
                if (!w_found) begin
                    // Nothing enabled: park the pointer and present nothing.
                    w_out_d       = '0;
                    w_out_valid_d = 1'b0;
                    w_dwell_d     = '0;
                end else begin
                    w_out_d       = w_ptr_data;
                    w_out_valid_d = i_en_mask[r_ptr];
                    w_wrap_d      = r_wrap_pend;
                    if (!i_en_mask[r_ptr] || (w_dwell_eff == DWELL_LAST)) begin
                        w_ptr_d       = w_next;
                        w_dwell_d     = '0;
                        w_wrap_pend_d = w_wrapped;
                    end else begin
                        w_dwell_d = w_dwell_eff + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_MANUAL;
            r_ptr       <= '0;
            r_dwell     <= '0;
            r_out       <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_wrap      <= 1'b0;
            r_wrap_pend <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_ptr       <= w_ptr_d;
            r_dwell     <= w_dwell_d;
            r_out       <= w_out_d;
            r_out_ch    <= w_out_ch_d;
            r_out_valid <= w_out_valid_d;
            r_wrap      <= w_wrap_d;
            r_wrap_pend <= w_wrap_pend_d;
        end
    end

    assign o_out       = r_out;
    assign o_out_ch    = r_out_ch;
    assign o_out_valid = r_out_valid;
    assign o_wrap      = r_wrap;

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed-vector bench for mux_scan_n: driver queues hand-computed responses, monitor checks them.
module tb_mux_scan_n;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned N     = 4;
    localparam int unsigned DWELL = 4;

    typedef struct packed {
        int         idx;
        logic [7:0] out;
        logic [1:0] ch;
        logic       valid;
        logic       wrap;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [N*WIDTH-1:0]  din;
    logic [1:0]          sel;
    logic                mode;
    logic [N-1:0]        en_mask;
    logic [WIDTH-1:0]    out;
    logic [1:0]          out_ch;
    logic                out_valid;
    logic                wrap;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   n_push = 0;

    always #5 clk = ~clk;

    mux_scan_n #(
        .WIDTH (WIDTH),
        .N     (N),
        .DWELL (DWELL)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in        (din),
        .i_sel       (sel),
        .i_mode      (mode),
        .i_en_mask   (en_mask),
        .o_out       (out),
        .o_out_ch    (out_ch),
        .o_out_valid (out_valid),
        .o_wrap      (wrap)
    );

    // Drive n cycles of one input vector at the falling edge; queue the response due after the next rise.
    task automatic step(input int n, input logic r, input logic m, input logic [1:0] s,
                        input logic [3:0] k, input logic [7:0] eo, input logic [1:0] ec,
                        input logic ev, input logic ew);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst     = r;
            mode    = m;
            sel     = s;
            en_mask = k;
            e.idx   = n_push;
            e.out   = eo;
            e.ch    = ec;
            e.valid = ev;
            e.wrap  = ew;
            exp_q.push_back(e);
            n_push++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (out !== e.out || out_ch !== e.ch || out_valid !== e.valid
                    || wrap !== e.wrap) begin
                    n_err++;
                    $display("FAIL vec%0d: got out=%h ch=%0d valid=%b wrap=%b, want out=%h ch=%0d valid=%b wrap=%b",
                             e.idx, out, out_ch, out_valid, wrap, e.out, e.ch, e.valid, e.wrap);
                end
            end
        end
    end

    initial begin : driver
        rst     = 1'b1;
        mode    = 1'b1;
        sel     = 2'd3;
        en_mask = 4'h5;
        din     = 32'hD3C2_B1A0;

        // Reset with garbage on the other inputs
        step(2, 1, 1, 3, 4'h5, 8'h00, 0, 0, 0);

        // Manual select, incl. a disabled channel
        step(1, 0, 0, 0, 4'hF, 8'hA0, 0, 1, 0);
        step(1, 0, 0, 1, 4'hF, 8'hB1, 1, 1, 0);
        step(1, 0, 0, 2, 4'hF, 8'hC2, 2, 1, 0);
        step(1, 0, 0, 3, 4'hF, 8'hD3, 3, 1, 0);
        step(1, 0, 0, 2, 4'b1011, 8'hC2, 2, 0, 0);
        step(1, 0, 0, 0, 4'b1011, 8'hA0, 0, 1, 0);

        // Scan 0,1,3 with ch2 skipped; wrap rides with the return to ch0
        step(4, 0, 1, 0, 4'b1011, 8'hA0, 0, 1, 0);
        step(4, 0, 1, 0, 4'b1011, 8'hB1, 1, 1, 0);
        step(4, 0, 1, 0, 4'b1011, 8'hD3, 3, 1, 0);
        step(1, 0, 1, 0, 4'b1011, 8'hA0, 0, 1, 1);
        step(1, 0, 1, 0, 4'b1011, 8'hA0, 0, 1, 0);

        // Reset mid-dwell (dwell_cnt=2), then scan restarts at ch0 with a full dwell
        step(1, 1, 1, 0, 4'b1011, 8'h00, 0, 0, 0);
        step(4, 0, 1, 0, 4'hF, 8'hA0, 0, 1, 0);
        step(1, 0, 1, 0, 4'hF, 8'hB1, 1, 1, 0);

        // ptr=1 at dwell_cnt=1 loses its enable: immediate move to the only channel, ch2
        step(1, 0, 1, 0, 4'b0100, 8'hB1, 1, 0, 0);
        step(4, 0, 1, 0, 4'b0100, 8'hC2, 2, 1, 0);
        for (int j = 0; j < 2; j++) begin
            step(1, 0, 1, 0, 4'b0100, 8'hC2, 2, 1, 1);
            step(3, 0, 1, 0, 4'b0100, 8'hC2, 2, 1, 0);
        end

        // Nothing enabled (a wrap was pending and must be swallowed), then only ch3
        step(3, 0, 1, 0, 4'b0000, 8'h00, 2, 0, 0);
        step(1, 0, 1, 0, 4'b1000, 8'hC2, 2, 0, 0);
        step(1, 0, 1, 0, 4'b1000, 8'hD3, 3, 1, 0);

        // All enabled: finish ch3's dwell, wrap to ch0, run on to ch2
        step(3, 0, 1, 0, 4'hF, 8'hD3, 3, 1, 0);
        step(1, 0, 1, 0, 4'hF, 8'hA0, 0, 1, 1);
        step(3, 0, 1, 0, 4'hF, 8'hA0, 0, 1, 0);
        step(4, 0, 1, 0, 4'hF, 8'hB1, 1, 1, 0);
        step(1, 0, 1, 0, 4'hF, 8'hC2, 2, 1, 0);

        // Back to manual at sel=1, then scan resumes from ch1 with a full dwell
        step(1, 0, 0, 1, 4'hF, 8'hB1, 1, 1, 0);
        step(4, 0, 1, 0, 4'hF, 8'hB1, 1, 1, 0);
        step(1, 0, 1, 0, 4'hF, 8'hC2, 2, 1, 0);

        @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d responses never checked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
